// File: rtl/dmem_axil_bridge.sv
// Bridges the core's single-outstanding load/store port onto an AXI4-Lite master.
// The core is stalled for the whole transaction and then sees a one-cycle completion beat.
module dmem_axil_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rmem_i,
    input  logic              wmem_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wmask_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [2:0]        dbg_state
);
    // Handshake rule: a transfer happens on a cycle where valid and ready are both high;
    // valids come straight from registers, are held until that cycle and drop the cycle after.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WREQ  = 3'd3,
        WRESP = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              arvalid_q, awvalid_q, wvalid_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              aw_hs, w_hs, aw_done, w_done;
    logic [ADDR_W-1:0] addr_aligned;
    logic              unused_bits;

    assign addr_aligned = {addr_i[ADDR_W-1:2], 2'b00};
    assign unused_bits  = ^{addr_i[1:0], m_axi_rresp[0], m_axi_bresp[0]};

    assign aw_hs   = awvalid_q & m_axi_awready;
    assign w_hs    = wvalid_q & m_axi_wready;
    // A channel is finished once its valid has dropped or it handshakes this cycle.
    assign aw_done = ~awvalid_q | m_axi_awready;
    assign w_done  = ~wvalid_q | m_axi_wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wmem_i) begin
                    state_nxt = WREQ;
                end else if (rmem_i) begin
                    state_nxt = RADDR;
                end
            end
            RADDR:   if (arvalid_q && m_axi_arready) state_nxt = RDATA;
            RDATA:   if (m_axi_rvalid) state_nxt = DONE;
            WREQ:    if (aw_done && w_done) state_nxt = WRESP;
            WRESP:   if (m_axi_bvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Stores win over loads when both are requested together.
                    if (wmem_i) begin
                        addr_q    <= addr_aligned;
                        wdata_q   <= wdata_i;
                        wstrb_q   <= wmask_i;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end else if (rmem_i) begin
                        addr_q    <= addr_aligned;
                        arvalid_q <= 1'b1;
                    end
                end
                RADDR: begin
                    if (m_axi_arready) arvalid_q <= 1'b0;
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        rdata_q <= m_axi_rdata;
                        err_q   <= m_axi_rresp[1];
                    end
                end
                WREQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                end
                WRESP: begin
                    if (m_axi_bvalid) err_q <= m_axi_bresp[1];
                end
                DONE:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b1;
        case (state)
            IDLE:    stall_o = rmem_i | wmem_i;
            DONE:    stall_o = 1'b0;
            default: stall_o = 1'b1;
        endcase
    end

    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state == WRESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state == RDATA);
    assign dbg_state     = state;
endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Directed bench for dmem_axil_bridge: a cycle-stepped AXI4-Lite slave with per-channel
// wait counts, a monitor of handshakes/stalls, and per-scenario hand-computed expectations.
module tb_dmem_axil_bridge;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rmem_i = 1'b0, wmem_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [31:0]       wdata_i = '0;
  logic [3:0]        wmask_i = '0;
  logic [31:0]       rdata_o;
  logic              stall_o, err_o;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]        m_axi_awprot, m_axi_arprot;
  logic              m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic              m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]        m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0]       m_axi_rdata = '0;
  logic [2:0]        dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // slave configuration and state
  int ar_delay, r_delay, aw_delay, w_delay, b_delay;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp, cfg_bresp;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit r_pend, b_pend, aw_got, w_got;

  // monitor
  int cyc, stall_cnt, done_seen, err_cnt, ar_hs, aw_hs, w_hs, b_hs, split_cnt;
  logic        done_err;
  logic [31:0] done_rdata, last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  int ar_cyc_q[$];

  dmem_axil_bridge #(.ADDR_W(ADDR_W), .PROT(3'b000)) dut (
    .clk(clk), .reset(reset), .rmem_i(rmem_i), .wmem_i(wmem_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic clear_bench();
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    cfg_rdata = '0; cfg_rresp = '0; cfg_bresp = '0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    cyc = 0; stall_cnt = 0; done_seen = 0; err_cnt = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; split_cnt = 0;
    done_err = 1'b0; done_rdata = '0; last_araddr = '0; last_awaddr = '0;
    last_wdata = '0; last_wstrb = '0;
    ar_cyc_q.delete();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
  endtask

  // One clock cycle: drive the slave from the registered DUT valids, observe, advance.
  task automatic cycle();
    bit arh, awh, wh, rh, bh;
    m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);
    m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
    m_axi_wready  = m_axi_wvalid && (w_cnt >= w_delay);
    m_axi_rvalid  = r_pend && (r_cnt >= r_delay);
    m_axi_rdata   = m_axi_rvalid ? cfg_rdata : 32'h0;
    m_axi_rresp   = cfg_rresp;
    m_axi_bvalid  = b_pend && (b_cnt >= b_delay);
    m_axi_bresp   = cfg_bresp;
    #1;
    arh = m_axi_arvalid && m_axi_arready;
    awh = m_axi_awvalid && m_axi_awready;
    wh  = m_axi_wvalid && m_axi_wready;
    rh  = m_axi_rvalid && m_axi_rready;
    bh  = m_axi_bvalid && m_axi_bready;
    if (stall_o) stall_cnt++;
    if (err_o) err_cnt++;
    if ((rmem_i || wmem_i) && !stall_o) begin
      done_seen++;
      done_err = err_o;
      done_rdata = rdata_o;
    end
    if (arh) begin ar_hs++; last_araddr = m_axi_araddr; ar_cyc_q.push_back(cyc); end
    if (awh) begin aw_hs++; last_awaddr = m_axi_awaddr; end
    if (wh) begin w_hs++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb; end
    if (m_axi_awvalid != m_axi_wvalid) split_cnt++;
    if (bh) b_hs++;
    ar_cnt = (m_axi_arvalid && !arh) ? ar_cnt + 1 : 0;
    aw_cnt = (m_axi_awvalid && !awh) ? aw_cnt + 1 : 0;
    w_cnt  = (m_axi_wvalid && !wh) ? w_cnt + 1 : 0;
    if (r_pend && !m_axi_rvalid) r_cnt++;
    if (rh) r_pend = 0;
    if (arh) begin r_pend = 1; r_cnt = 0; end
    if (b_pend && !m_axi_bvalid) b_cnt++;
    if (bh) b_pend = 0;
    aw_got |= awh;
    w_got  |= wh;
    if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rmem_i = 0; wmem_i = 0;
    repeat (2) @(negedge clk);
    vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    vectors++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0) begin
      miscompares++; $display("FAIL rst_valid_ready: got %b want 00000", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}); end
    vectors++; if ({rdata_o, err_o} !== 33'h0) begin miscompares++; $display("FAIL rst_rdata_err: got %h want 0", {rdata_o, err_o}); end
    vectors++; if ({m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== 68'h0) begin
      miscompares++; $display("FAIL rst_regs: got %h want 0", {m_axi_araddr, m_axi_wdata, m_axi_wstrb}); end
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall_idle: got %b want 0", stall_o); end
    rmem_i = 1; #1;
    vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL rst_stall_req: got %b want 1", stall_o); end
    rmem_i = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_zero_wait();
    clear_bench();
    cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
    addr_i = 32'h0000_1006; rmem_i = 1;
    for (int i = 0; i < 40 && done_seen == 0; i++) cycle();
    rmem_i = 0;
    vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL rd0_done: got %0d want 1", done_seen); end
    vectors++; if (last_araddr !== 32'h0000_1004) begin miscompares++; $display("FAIL rd0_araddr: got %h want 00001004", last_araddr); end
    vectors++; if (stall_cnt !== 3) begin miscompares++; $display("FAIL rd0_stall: got %0d want 3", stall_cnt); end
    vectors++; if (done_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd0_rdata: got %h want deadbeef", done_rdata); end
    vectors++; if (done_err !== 1'b0) begin miscompares++; $display("FAIL rd0_err: got %b want 0", done_err); end
    vectors++; if (m_axi_arprot !== 3'b000) begin miscompares++; $display("FAIL rd0_arprot: got %b want 000", m_axi_arprot); end
  endtask

  task automatic test_write_aw_first();
    clear_bench();
    aw_delay = 0; w_delay = 2; cfg_bresp = 2'b00;
    addr_i = 32'h20; wdata_i = 32'h1122_3344; wmask_i = 4'b0011; wmem_i = 1;
    cycle();
    vectors++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
      miscompares++; $display("FAIL wr_entry_valids: got %b want 11", {m_axi_awvalid, m_axi_wvalid}); end
    cycle();
    vectors++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b01) begin
      miscompares++; $display("FAIL wr_aw_dropped: got %b want 01", {m_axi_awvalid, m_axi_wvalid}); end
    for (int i = 0; i < 40 && done_seen == 0; i++) cycle();
    wmem_i = 0;
    vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL wr_done: got %0d want 1", done_seen); end
    vectors++; if ({aw_hs, w_hs, b_hs} !== {32'd1, 32'd1, 32'd1}) begin
      miscompares++; $display("FAIL wr_hs_counts: got aw=%0d w=%0d b=%0d want 1 1 1", aw_hs, w_hs, b_hs); end
    vectors++; if (last_awaddr !== 32'h20) begin miscompares++; $display("FAIL wr_awaddr: got %h want 00000020", last_awaddr); end
    vectors++; if ({last_wdata, last_wstrb} !== {32'h1122_3344, 4'b0011}) begin
      miscompares++; $display("FAIL wr_wdata_wstrb: got %h/%b want 11223344/0011", last_wdata, last_wstrb); end
    vectors++; if (stall_cnt !== 5) begin miscompares++; $display("FAIL wr_stall: got %0d want 5", stall_cnt); end
    vectors++; if (done_err !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b want 0", done_err); end
    vectors++; if (done_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_rdata_hold: got %h want deadbeef", done_rdata); end
  endtask

  task automatic test_read_error_wait();
    clear_bench();
    r_delay = 5; cfg_rdata = 32'hCAFE_0001; cfg_rresp = 2'b10;
    addr_i = 32'h200; rmem_i = 1;
    for (int i = 0; i < 40 && done_seen == 0; i++) cycle();
    rmem_i = 0; #1;
    vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL rderr_done: got %0d want 1", done_seen); end
    vectors++; if (stall_cnt !== 8) begin miscompares++; $display("FAIL rderr_stall: got %0d want 8", stall_cnt); end
    vectors++; if (done_err !== 1'b1) begin miscompares++; $display("FAIL rderr_err_done: got %b want 1", done_err); end
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL rderr_err_cycles: got %0d want 1", err_cnt); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL rderr_err_after: got %b want 0", err_o); end
    vectors++; if (done_rdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL rderr_rdata: got %h want cafe0001", done_rdata); end
  endtask

  task automatic test_back_to_back();
    int first_cyc, second_cyc;
    clear_bench();
    cfg_rdata = 32'h1234_5678;
    addr_i = 32'h40; rmem_i = 1;
    for (int i = 0; i < 8; i++) cycle();
    rmem_i = 0;
    first_cyc = (ar_cyc_q.size() > 0) ? ar_cyc_q[0] : -1;
    second_cyc = (ar_cyc_q.size() > 1) ? ar_cyc_q[1] : -1;
    vectors++; if (ar_hs !== 2) begin miscompares++; $display("FAIL b2b_ar_count: got %0d want 2", ar_hs); end
    vectors++; if (first_cyc !== 1 || second_cyc !== 5) begin
      miscompares++; $display("FAIL b2b_ar_cycles: got %0d,%0d want 1,5", first_cyc, second_cyc); end
    vectors++; if (done_seen !== 2) begin miscompares++; $display("FAIL b2b_done: got %0d want 2", done_seen); end
    vectors++; if (last_araddr !== 32'h40) begin miscompares++; $display("FAIL b2b_araddr: got %h want 00000040", last_araddr); end
  endtask

  task automatic test_write_joint_delay_err();
    clear_bench();
    aw_delay = 4; w_delay = 4; cfg_bresp = 2'b11;
    addr_i = 32'h100; wdata_i = 32'h0F0F_0F0F; wmask_i = 4'hF; wmem_i = 1;
    for (int i = 0; i < 40 && done_seen == 0; i++) cycle();
    wmem_i = 0; #1;
    vectors++; if (done_seen !== 1) begin miscompares++; $display("FAIL wrj_done: got %0d want 1", done_seen); end
    vectors++; if (split_cnt !== 0) begin miscompares++; $display("FAIL wrj_split: got %0d want 0", split_cnt); end
    vectors++; if (stall_cnt !== 7) begin miscompares++; $display("FAIL wrj_stall: got %0d want 7", stall_cnt); end
    vectors++; if (done_err !== 1'b1) begin miscompares++; $display("FAIL wrj_err: got %b want 1", done_err); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL wrj_err_after: got %b want 0", err_o); end
  endtask

  task automatic test_both_req_reset_in_wresp();
    clear_bench();
    b_delay = 20;
    addr_i = 32'h83; wdata_i = 32'hA5A5_A5A5; wmask_i = 4'b0000; rmem_i = 1; wmem_i = 1;
    cycle();
    cycle();
    vectors++; if (m_axi_bready !== 1'b1) begin miscompares++; $display("FAIL both_in_wresp: got bready=%b want 1", m_axi_bready); end
    vectors++; if (ar_hs !== 0 || m_axi_arvalid !== 1'b0) begin
      miscompares++; $display("FAIL both_no_ar: got ar_hs=%0d arvalid=%b want 0 0", ar_hs, m_axi_arvalid); end
    vectors++; if ({aw_hs, w_hs} !== {32'd1, 32'd1}) begin
      miscompares++; $display("FAIL both_write_hs: got aw=%0d w=%0d want 1 1", aw_hs, w_hs); end
    vectors++; if ({last_awaddr, last_wstrb} !== {32'h80, 4'b0000}) begin
      miscompares++; $display("FAIL both_addr_strb: got %h/%b want 00000080/0000", last_awaddr, last_wstrb); end
    reset = 1'b1; #1;
    vectors++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0) begin
      miscompares++; $display("FAIL midrst_valid_ready: got %b want 00000", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}); end
    vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL midrst_stall_req: got %b want 1", stall_o); end
    rmem_i = 0; wmem_i = 0; #1;
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL midrst_stall_noreq: got %b want 0", stall_o); end
    clear_bench();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    clear_bench();
    test_reset();
    test_read_zero_wait();
    test_write_aw_first();
    test_read_error_wait();
    test_back_to_back();
    test_write_joint_delay_err();
    test_both_req_reset_in_wresp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_axil_bridge.md
Name: dmem_axil_bridge

Overview:
- Converts the core's single-outstanding data-memory port into AXI4-Lite master transactions: rmem/wmem, addr, data, wmask in; data_i, data_stall, data_err out.
- Sits between the core's load/store port and the system AXI4-Lite interconnect.
- Holds the core's data port in stall for the full duration of each transaction, then returns read data and an error flag on a one-cycle completion beat.

Parameters:
- ADDR_W, 32, width of core address and AXI address buses.
- PROT, 3'b000, constant driven on awprot/arprot (unprivileged, secure, data).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rmem_i  input  1  core load request, level, held stable while stall_o=1.
- wmem_i  input  1  core store request, level, held stable while stall_o=1.
- addr_i  input  ADDR_W  core byte address.
- wdata_i  input  32  store data, already lane-aligned.
- wmask_i  input  4  store byte-lane mask.
- rdata_o  output  32  load data to core.
- stall_o  output  1  data_stall to core.
- err_o  output  1  data_err to core.
- m_axi_awaddr  output  ADDR_W  write address.
- m_axi_awprot  output  3  constant PROT.
- m_axi_awvalid  output  1  write-address valid.
- m_axi_awready  input  1  write-address ready.
- m_axi_wdata  output  32  write data.
- m_axi_wstrb  output  4  write strobes.
- m_axi_wvalid  output  1  write-data valid.
- m_axi_wready  input  1  write-data ready.
- m_axi_bresp  input  2  write response.
- m_axi_bvalid  input  1  write-response valid.
- m_axi_bready  output  1  write-response ready.
- m_axi_araddr  output  ADDR_W  read address.
- m_axi_arprot  output  3  constant PROT.
- m_axi_arvalid  output  1  read-address valid.
- m_axi_arready  input  1  read-address ready.
- m_axi_rdata  input  32  read data.
- m_axi_rresp  input  2  read response.
- m_axi_rvalid  input  1  read-data valid.
- m_axi_rready  output  1  read-data ready.

Behaviour:
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- Reset: state=IDLE. All valid and ready outputs 0; rdata_o=0; err_o=0. The address, data and strobe registers are cleared to 0.
- Reset mid-transaction: the FSM returns to IDLE immediately and all valids drop, asynchronously. The system bus is reset from the same source.
- stall_o is combinational:
  - IDLE: stall_o = rmem_i | wmem_i.
  - RADDR, RDATA, WREQ, WRESP: stall_o = 1.
  - DONE: stall_o = 0.
- IDLE:
  - wmem_i=1: latch {addr_i[31:2],2'b00}, wdata_i and wmask_i; go to WREQ.
  - else rmem_i=1: latch the word-aligned address; go to RADDR.
  - wmem_i has priority if both requests are high; the read is not performed.
  - wmask_i=0 with wmem_i=1 still issues a write with wstrb=0.
- RADDR: arvalid=1 from a register. On arvalid & arready, go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata into rdata_o and set err_o=rresp[1]; go to DONE.
  - OKAY and EXOKAY give err=0; SLVERR and DECERR give err=1.
- WREQ: awvalid and wvalid are both asserted on entry.
  - Each handshakes independently: either may complete first, or both in the same cycle.
  - Each valid drops the cycle after its own handshake and is never re-asserted.
  - When both handshakes are complete, go to WRESP.
- WRESP: bready=1. On bvalid, set err_o=bresp[1] and go to DONE. rdata_o is unchanged.
- DONE, one cycle:
  - stall_o=0 and err_o is valid; the core samples rdata_o and err_o here.
  - Then go to IDLE.
  - err_o is cleared when leaving DONE, so it is asserted for exactly one cycle per transaction.
- The core request is still asserted during DONE and is not re-issued. Any request visible in IDLE the following cycle is treated as new, even if the address is identical.
- rdata_o holds the last read value until the next read completion.
- Minimum latency with zero-wait slaves:
  - Read: request cycle (IDLE) → RADDR → RDATA → DONE = 3 stall cycles.
  - Write: IDLE → WREQ → WRESP → DONE = 3 stall cycles.
- Valid/ready rules:
  - No valid is dropped before its handshake.
  - No combinational path exists from any AXI ready input to any AXI valid output.
  - stall_o depends combinationally only on state, rmem_i and wmem_i.
- Only one outstanding transaction at a time. awaddr, wdata, wstrb and araddr are stable while their valids are high.

Test Plan:
- Read, zero-wait slave, addr 0x0000_1006, slave returns 0xDEADBEEF/OKAY → araddr=0x0000_1004; stall_o high for 3 cycles; in DONE rdata_o=0xDEADBEEF, err_o=0.
- Write 0x1122_3344, mask 4'b0011, addr 0x20; slave asserts awready 2 cycles before wready → awvalid drops after its handshake while wvalid stays high; one bvalid; DONE with err_o=0.
- Read with rresp=2'b10 and 5 rvalid wait cycles → stall_o high for 8 cycles; err_o=1 for exactly the DONE cycle, then 0.
- Back-to-back loads to the same address 0x40 (rmem_i held across DONE) → exactly two AR handshakes, separated by the DONE and IDLE cycles.
- rmem_i=1 and wmem_i=1 together → write issued, no AR; then reset asserted while in WRESP → all valids and readies 0 immediately, state IDLE, stall_o follows the request inputs.
- Write with awready and wready both delayed 4 cycles and granted in the same cycle → direct transition to WRESP; bresp=2'b11 → err_o=1 in DONE.
